// File: rtl/sdram_packer_pkg.sv
// ---------------------------------------------------------------------------
// sdram_packer_pkg
// Shared types and constants for the SDRAM write packer:
//   packed_word_t : one 16-bit SDRAM word with its word address and byte mask
//   pack_state_t  : byte-merge state (no pending word / partial word pending)
//   MASK_*        : byte-enable encodings ([0] = low/even byte, [1] = high/odd byte)
//   lane_word()   : builds a word carrying a single byte in the addressed lane
// WORD_ADDR_W is the storage width of the word address inside the FIFO.
// It must be at least ADDRESS_SIZE-1 of the top module.
// ---------------------------------------------------------------------------
package sdram_packer_pkg;

  localparam int WORD_ADDR_W = 27;

  localparam logic [1:0] MASK_LO   = 2'b01;
  localparam logic [1:0] MASK_HI   = 2'b10;
  localparam logic [1:0] MASK_FULL = 2'b11;

  typedef enum logic {
    EMPTY   = 1'b0,
    PARTIAL = 1'b1
  } pack_state_t;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] addr;
    logic [15:0]            data;
    logic [1:0]             mask;
  } packed_word_t;

  // Place one byte into its lane; the other lane's data and mask stay zero so
  // that a later merge can simply OR the two single-lane words together.
  function automatic packed_word_t lane_word(input logic [WORD_ADDR_W-1:0] addr,
                                             input logic                   lane,
                                             input logic [7:0]             data);
    packed_word_t w;
    w.addr = addr;
    if (lane) begin
      w.data = {data, 8'h00};
      w.mask = MASK_HI;
    end else begin
      w.data = {8'h00, data};
      w.mask = MASK_LO;
    end
    return w;
  endfunction

endpackage

// File: rtl/sdram_write_packer_fifo.sv
// ---------------------------------------------------------------------------
// packer_fifo
// Single-clock show-ahead FIFO of packed_word_t words.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_word (ignored when full unless popping the same edge)
//   push_word   : word to store
//   pop         : discard head (ignored when empty)
//   head        : oldest stored word, valid whenever empty is low
//   full, empty : registered occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module packer_fifo
  import sdram_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  packed_word_t push_word,
  input  logic         pop,
  output packed_word_t head,
  output logic         full,
  output logic         empty
);

  localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           full_q, full_d;
  logic           empty_q, empty_d;
  logic           do_push;
  logic           do_pop;
  packed_word_t   mem_q [DEPTH];

  // Next pointers and occupancy flags; a push on a full FIFO is only taken
  // when the same edge frees a slot.
  always_comb begin
    do_pop  = pop & ~empty_q;
    do_push = push & (~full_q | do_pop);
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
              (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
  end

  // Pointer, flag and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      if (do_push) begin
        mem_q[wr_ptr_q[PTR_W-1:0]] <= push_word;
      end
    end
  end

  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/sdram_write_packer.sv
// ---------------------------------------------------------------------------
// sdram_write_packer
// Merges byte writes from the data loader into 16-bit SDRAM words with byte
// enables, queues them in a small FIFO and offers them to the SDRAM
// controller over a req/ack handshake. Single clock domain (clk_memory).
// Ports:
//   clk_memory, reset   : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data: byte write strobe, byte address, byte data
//   flush               : push any partially filled word
//   mem_req/mem_addr/mem_data/mem_mask : head word toward controller
//   mem_ack             : controller accepted the head word
//   busy                : partial word pending or FIFO not empty
//   overflow            : sticky, a word was dropped on a full FIFO
//   checksum            : only with SDRAM_PACKER_CHECKSUM_EN defined; 16-bit
//                         wrapping sum of all accepted wr_data bytes
// Build option: `define SDRAM_PACKER_CHECKSUM_EN to add the checksum port.
// ---------------------------------------------------------------------------
module sdram_write_packer
  import sdram_packer_pkg::*;
#(
  parameter int ADDRESS_SIZE  = 28,
  parameter int FIFO_DEPTH    = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                    clk_memory,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDRESS_SIZE-1:0] wr_addr,
  input  logic [7:0]              wr_data,
  input  logic                    flush,
  output logic                    mem_req,
  output logic [ADDRESS_SIZE-2:0] mem_addr,
  output logic [15:0]             mem_data,
  output logic [1:0]              mem_mask,
  input  logic                    mem_ack,
  output logic                    busy,
  output logic                    overflow
`ifdef SDRAM_PACKER_CHECKSUM_EN
  ,
  output logic [15:0]             checksum
`endif
);

  localparam bit               TIMEOUT_EN = (FLUSH_TIMEOUT != 0);
  localparam int               TMO_W      = (FLUSH_TIMEOUT > 2) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST   = TIMEOUT_EN ? TMO_W'(FLUSH_TIMEOUT - 1) : '0;
  localparam logic [TMO_W-1:0] TMO_ONE    = {{(TMO_W-1){1'b0}}, 1'b1};

  pack_state_t      state_q, state_d;
  packed_word_t     pend_q, pend_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             flush_pend_q, flush_pend_d;
  logic             overflow_q, overflow_d;
`ifdef SDRAM_PACKER_CHECKSUM_EN
  logic [15:0]      checksum_q, checksum_d;
`endif

  packed_word_t     new_word;
  packed_word_t     merged_word;
  packed_word_t     push_word;
  packed_word_t     fifo_head;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  // Pack state machine: merge, push, flush and idle-timeout decisions.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    tmo_d        = tmo_q;
    flush_pend_d = flush_pend_q;
    push         = 1'b0;
    push_word    = pend_q;

    new_word         = lane_word(WORD_ADDR_W'(wr_addr[ADDRESS_SIZE-1:1]), wr_addr[0], wr_data);
    merged_word.addr = pend_q.addr;
    merged_word.data = pend_q.data | new_word.data;
    merged_word.mask = pend_q.mask | new_word.mask;

    if (wr_en) begin
      tmo_d = '0;
      // A flush arriving with a byte is remembered and applied once that byte is packed.
      flush_pend_d = flush_pend_q | flush;
      case (state_q)
        EMPTY: begin
          pend_d  = new_word;
          state_d = PARTIAL;
        end
        PARTIAL: begin
          if ((new_word.addr == pend_q.addr) && ((pend_q.mask & new_word.mask) == 2'b00)) begin
            if (merged_word.mask == MASK_FULL) begin
              push      = 1'b1;
              push_word = merged_word;
              pend_d    = '0;
              state_d   = EMPTY;
            end else begin
              pend_d = merged_word;
            end
          end else begin
            // New word or a rewrite of a filled lane: retire the old word first.
            push      = 1'b1;
            push_word = pend_q;
            pend_d    = new_word;
          end
        end
        default: begin
          pend_d  = '0;
          state_d = EMPTY;
        end
      endcase
    end else if (state_q == PARTIAL) begin
      if (flush | flush_pend_q) begin
        push         = 1'b1;
        push_word    = pend_q;
        pend_d       = '0;
        state_d      = EMPTY;
        tmo_d        = '0;
        flush_pend_d = 1'b0;
      end else if (TIMEOUT_EN && (tmo_q == TMO_LAST)) begin
        push      = 1'b1;
        push_word = pend_q;
        pend_d    = '0;
        state_d   = EMPTY;
        tmo_d     = '0;
      end else if (TIMEOUT_EN) begin
        tmo_d = tmo_q + TMO_ONE;
      end else begin
        tmo_d = '0;
      end
    end else begin
      tmo_d        = '0;
      flush_pend_d = 1'b0;
    end
  end

  // Handshake and sticky overflow: a push onto a full FIFO is lost unless the
  // controller takes the head word on the same edge.
  always_comb begin
    pop        = ~fifo_empty & mem_ack;
    overflow_d = overflow_q | (push & fifo_full & ~pop);
  end

`ifdef SDRAM_PACKER_CHECKSUM_EN
  // Running checksum over every accepted byte.
  always_comb begin
    if (wr_en) begin
      checksum_d = checksum_q + {8'h00, wr_data};
    end else begin
      checksum_d = checksum_q;
    end
  end
`endif

  // Pack state, pending word and status registers.
  always_ff @(posedge clk_memory or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      pend_q       <= '0;
      tmo_q        <= '0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef SDRAM_PACKER_CHECKSUM_EN
      checksum_q   <= 16'h0000;
`endif
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      tmo_q        <= tmo_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
`ifdef SDRAM_PACKER_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  packer_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_memory),
    .rst      (reset),
    .push     (push),
    .push_word(push_word),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Word fields are forced to zero whenever no word is offered, so stale FIFO
  // contents never show on the bus (including directly after reset).
  assign mem_req  = ~fifo_empty;
  assign mem_addr = mem_req ? fifo_head.addr[ADDRESS_SIZE-2:0] : '0;
  assign mem_data = mem_req ? fifo_head.data : 16'h0000;
  assign mem_mask = mem_req ? fifo_head.mask : 2'b00;
  assign busy     = (state_q == PARTIAL) | ~fifo_empty;
  assign overflow = overflow_q;
`ifdef SDRAM_PACKER_CHECKSUM_EN
  assign checksum = checksum_q;
`endif

endmodule
